chunked_adder_seq: RTL and testbench
====================================

# chunked_adder_seq

Multi-cycle sequencer for wide binary addition that reuses one CHUNK-bit adder slice across successive cycles instead of building a full WIDTH-bit carry chain. It captures a WIDTH-bit operand pair through a valid/ready handshake and ripples the carry between chunks through a register. It presents the WIDTH-bit sum and final carry-out through a second valid/ready handshake. It sits in front of consumers of the 100-bit adder datapath where timing, not latency, is the constraint.

## Interface
- WIDTH, 100, operand and sum width; must be an exact multiple of CHUNK (elaboration error otherwise)
- CHUNK, 25, adder slice width; NCHUNK = WIDTH/CHUNK cycles per operation
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; one clock; polarity and synchronicity fixed
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept; high only in IDLE and never while rst_n=0
- A  input  WIDTH  operand A, sampled on accept
- B  input  WIDTH  operand B, sampled on accept
- Cin  input  1  carry-in into bit 0, sampled on accept
- in_sub  input  1  subtract request; present only with ADDER_SUB_EN
- out_valid  output  1  Sum/Cout hold a new result
- out_ready  input  1  consumer takes the result
- Sum  output  WIDTH  registered result
- Cout  output  1  registered carry out of bit WIDTH-1
- busy  output  1  state is RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A, B and Cin; clear chunk counter cnt; go to RUN.
- RUN:
  - Each cycle adds slice cnt: A[cnt*CHUNK +: CHUNK] + B[same] + carry_reg.
  - Writes the CHUNK-bit result into the internal accumulator and the slice carry into carry_reg.
  - carry_reg is loaded from Cin at accept.
  - At cnt=NCHUNK-1: copy accumulator to Sum and the final carry to Cout, set out_valid, go to DONE. Otherwise cnt++.
- DONE:
  - out_valid=1; Sum and Cout held.
  - On out_ready: clear out_valid, go to IDLE.
  - in_valid is ignored while busy.
- Sum and Cout change only on the RUN→DONE edge. They keep the last result through IDLE and RUN.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). No overflow flag.
- Reset (rst_n=0 at any rising edge, including mid-RUN or in DONE):
  - Next state is IDLE; cnt=0, carry_reg=0, accumulator=0.
  - Sum=0, Cout=0, out_valid=0, busy=0.
  - in_ready is forced 0 while rst_n=0 and rises the cycle after release.
  - An in-flight operation is discarded.

## Timing
- Accept at edge T0 → RUN on edges T0+1 … T0+NCHUNK.
- out_valid is visible after edge T0+NCHUNK, i.e. 4 cycles at the defaults.
- Handshake at edge Td → IDLE after Td; in_ready high in the following cycle.
- Minimum issue interval: NCHUNK+2 cycles with out_ready tied high (6 at defaults).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- out_valid stays high and Sum/Cout stay stable indefinitely while out_ready=0.

## Configuration
- ADDER_SUB_EN defined:
  - in_sub port exists and is sampled on accept.
  - in_sub=1 computes A + ~B + 1; Cin is ignored. Cout=1 means no borrow.
  - in_sub=0 behaves as plain addition.
- ADDER_SUB_EN undefined: no in_sub port; addition only.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → in_ready=0, out_valid=0, busy=0, Sum=0, Cout=0. After release, in_ready=1 on the next cycle.
- Full carry ripple: A=2^100-1, B=1, Cin=0 → Sum=0, Cout=1, out_valid exactly 4 cycles after the accept edge.
- Chunk boundary and carry-in:
  - A=2^25-1, B=1, Cin=0 → Sum=2^25, Cout=0.
  - A=B=0, Cin=1 → Sum=1, Cout=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and new operands → out_valid, Sum and Cout held, in_ready=0, new operands not taken. Release → IDLE and in_ready=1 one cycle later.
- Reset mid-operation: assert rst_n=0 when cnt=2 → after that edge busy=0 and Sum=0. The next operation, 7+9 with Cin=0, gives Sum=16.
- Random: 500 random A/B/Cin operations with random out_ready, checked against a 101-bit reference model. With ADDER_SUB_EN, A=5, B=7, in_sub=1 → Sum=2^100-2, Cout=0.

Source files
------------

// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: WIDTH-bit add over NCHUNK cycles using one CHUNK-bit slice; `ADDER_SUB_EN adds in_sub (A + ~B + 1)
module chunked_adder_seq #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_n;
  logic [CHUNK-1:0] s_sl;
  logic [CW-1:0] cnt;
  logic carry, c_sl, rdy, sub, accept, last;
`ifdef ADDER_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif
  assign in_ready = rdy & rst_n;
  assign accept = in_valid & in_ready;
  assign last = cnt == CW'(NCHUNK - 1);
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (accept ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
    {c_sl, s_sl} = {1'b0, a_q[32'(cnt) * CHUNK +: CHUNK]} + {1'b0, b_q[32'(cnt) * CHUNK +: CHUNK]} + (CHUNK + 1)'(carry);
    acc_n = acc;
    acc_n[32'(cnt) * CHUNK +: CHUNK] = s_sl;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else begin
      state <= state_n;
      rdy   <= state_n == IDLE;
    end
  end
  // Subtraction folds into the same slice: invert B and force the carry-in to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= sub ? ~B : B;
      carry <= sub | Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_n;
      carry <= c_sl;
      cnt   <= cnt + 1'b1;
      if (last) begin
        Sum  <= acc_n;
        Cout <= c_sl;
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder_seq.sv
// tb_chunked_adder_seq: directed and random checks of chunked_adder_seq at WIDTH=100, CHUNK=25
module tb_chunked_adder_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, Cin = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, Cout, busy;
  logic [99:0] A = '0, B = '0, Sum;
`ifdef ADDER_SUB_EN
  logic in_sub = 1'b0;
`endif
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  chunked_adder_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef ADDER_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [99:0] a, input logic [99:0] b, input logic c);
    int n = 0;
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask
  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  initial begin
    int lat, n;
    logic hs;
    logic [127:0] ra, rb;
    logic [100:0] ref_sum;
    logic rc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    rst_n = 1'b1;
    #1 chk("release_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("release_in_ready_high", in_ready, 1);
    issue('1, 100'd1, 1'b0);
    wait_done(lat);
    chk("ripple_latency", lat, 4);
    chk("ripple_sum", Sum, 0);
    chk("ripple_cout", Cout, 1);
    take();
    issue(100'h1FFFFFF, 100'd1, 1'b0);
    wait_done(lat);
    chk("boundary_sum", Sum, 128'h2000000);
    chk("boundary_cout", Cout, 0);
    take();
    issue(100'd0, 100'd0, 1'b1);
    wait_done(lat);
    chk("cin_sum", Sum, 1);
    chk("cin_cout", Cout, 0);
    take();
    issue(100'd3, 100'd4, 1'b0);
    wait_done(lat);
    A = 100'd9; B = 100'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", Sum, 7);
      chk("bp_cout", Cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take();
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_idle_sum_held", Sum, 7);
    issue(100'hABCDEF, 100'h123456, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", Sum, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    issue(100'd7, 100'd9, 1'b0);
    wait_done(lat);
    chk("after_rst_sum", Sum, 16);
    chk("after_rst_cout", Cout, 0);
    take();
`ifdef ADDER_SUB_EN
    in_sub = 1'b1;
    issue(100'd5, 100'd7, 1'b1);
    in_sub = 1'b0;
    wait_done(lat);
    chk("sub_sum", Sum, {28'd0, {99{1'b1}}, 1'b0});
    chk("sub_cout", Cout, 0);
    take();
`endif
    for (int k = 0; k < 500; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra[99:0]} + {1'b0, rb[99:0]} + 101'(rc);
      issue(ra[99:0], rb[99:0], rc);
      wait_done(lat);
      chk("rand_latency", lat, 4);
      chk("rand_sum", Sum, ref_sum[99:0]);
      chk("rand_cout", Cout, ref_sum[100]);
      n = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_ready & out_valid;
        @(posedge clk);
        #1 n++;
        @(negedge clk);
      end while (!hs && n < 50);
      out_ready = 1'b0;
      if (!hs) chk("rand_handshake_timeout", 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
